// File: rtl/prt_vtb_pkg.sv
// Shared types and constants for the video toolbox timing monitor.
package prt_vtb_pkg;

  localparam int STA_W = 16;
  localparam logic [STA_W-1:0] STA_MAX = '1;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_MEASURE
  } vtm_state_e;

  typedef struct packed {
    logic [STA_W-1:0] htot;
    logic [STA_W-1:0] hact;
    logic [STA_W-1:0] vtot;
    logic [STA_W-1:0] vact;
  } vtm_timing_t;

  function automatic logic [STA_W-1:0] sat_inc(input logic [STA_W-1:0] v);
    return (v == STA_MAX) ? v : v + 1'b1;
  endfunction

  // Cycle count to pixel count, clamped to the status width.
  function automatic logic [STA_W-1:0] sat_mul(input logic [STA_W-1:0] v, input int unsigned k);
    logic [31:0] p;
    p = 32'(v) * k;
    return (p > 32'(STA_MAX)) ? STA_MAX : p[STA_W-1:0];
  endfunction

endpackage

// File: rtl/prt_vtb_vtm_crc.sv
// Parallel CRC-16-CCITT over one P_W-bit word per enabled cycle, MSB first.
module prt_vtb_vtm_crc
  import prt_vtb_pkg::*;
#(
  parameter int P_W = 48
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           en,
  input  logic [P_W-1:0] data,
  output logic [15:0]    crc
);

  logic [15:0] crc_next;

  // A clear coinciding with an enable folds the word into a fresh CRC.
  always_comb begin
    crc_next = clr ? CRC_INIT : crc;
    for (int i = P_W - 1; i >= 0; i--) begin
      crc_next = {crc_next[14:0], 1'b0} ^ ((crc_next[15] ^ data[i]) ? CRC_POLY : 16'h0000);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc_next;
    end else if (clr) begin
      crc <= CRC_INIT;
    end
  end

endmodule

// File: rtl/prt_vtb_vtm.sv
// Video timing monitor: per-frame h/v total/active, frame count and lock.
// Define PRT_VTB_VTM_CRC_EN to build the per-frame active-pixel CRC.
module prt_vtb_vtm
  import prt_vtb_pkg::*;
#(
  parameter int P_PPC       = 2,
  parameter int P_BPC       = 8,
  parameter int P_LOCK_FRMS = 2
) (
  input  logic                   CLK_IN,
  input  logic                   RST_IN,
  input  logic                   CKE_IN,
  input  logic                   CTL_RUN_IN,
  input  logic                   VID_VS_IN,
  input  logic                   VID_HS_IN,
  input  logic                   VID_DE_IN,
  input  logic [P_BPC*P_PPC-1:0] VID_R_IN,
  input  logic [P_BPC*P_PPC-1:0] VID_G_IN,
  input  logic [P_BPC*P_PPC-1:0] VID_B_IN,
  output logic [STA_W-1:0]       STA_HTOTAL_OUT,
  output logic [STA_W-1:0]       STA_HACT_OUT,
  output logic [STA_W-1:0]       STA_VTOTAL_OUT,
  output logic [STA_W-1:0]       STA_VACT_OUT,
  output logic [STA_W-1:0]       STA_FRM_CNT_OUT,
  output logic [STA_W-1:0]       STA_CRC_OUT,
  output logic                   STA_LOCK_OUT,
  output logic                   STA_UPD_OUT
);

  localparam int unsigned PPC_U    = P_PPC;
  localparam logic [3:0]  LOCK_MAX = 4'(P_LOCK_FRMS - 1);

  vtm_state_e       state;
  logic             vs_r, vs_q, hs_r, hs_q, de_r;
  logic             vs_rise, hs_rise, frame_start, frame_close;
  logic [STA_W-1:0] h_cnt, de_cnt, line_tot, line_act, vtot, vact;
  logic [STA_W-1:0] h_cnt_n, de_cnt_n, line_tot_n, line_act_n, vtot_n, vact_n;
  logic             frm_sat, frm_sat_n;
  vtm_timing_t      cur_t, prev_t;
  logic             prev_valid;
  logic [3:0]       match_cnt, match_n;
  logic             upd_pend;

  always_ff @(posedge CLK_IN) begin
    if (!RST_IN) begin
      {vs_r, vs_q, hs_r, hs_q, de_r} <= '0;
    end else if (CKE_IN) begin
      // NOTE: non-blocking keeps vs_q holding the previous vs_r for edge detection
      vs_r <= VID_VS_IN;
      vs_q <= vs_r;
      hs_r <= VID_HS_IN;
      hs_q <= hs_r;
      de_r <= VID_DE_IN;
    end
  end

  assign vs_rise     = vs_r & ~vs_q;
  assign hs_rise     = hs_r & ~hs_q;
  assign frame_start = vs_rise && (state == ST_SYNC || state == ST_MEASURE);
  assign frame_close = vs_rise && (state == ST_MEASURE);

  // VS closes the frame first; a coincident HS then counts into the new frame.
  always_comb begin
    // NOTE: every variable gets a default here so no path infers a latch
    h_cnt_n    = sat_inc(h_cnt);
    de_cnt_n   = de_r ? sat_inc(de_cnt) : de_cnt;
    line_tot_n = line_tot;
    line_act_n = frame_start ? '0 : line_act;
    vtot_n     = frame_start ? '0 : vtot;
    vact_n     = frame_start ? '0 : vact;
    frm_sat_n  = frame_start ? 1'b0 : frm_sat;
    if (hs_rise) begin
      line_tot_n = sat_mul(h_cnt, PPC_U);
      frm_sat_n  = frm_sat_n | (line_tot_n == STA_MAX);
      if (de_cnt != '0) begin
        line_act_n = sat_mul(de_cnt, PPC_U);
        vact_n     = sat_inc(vact_n);
        frm_sat_n  = frm_sat_n | (line_act_n == STA_MAX);
      end
      vtot_n   = sat_inc(vtot_n);
      h_cnt_n  = 16'd1;
      de_cnt_n = '0;
    end
    frm_sat_n = frm_sat_n | (h_cnt_n == STA_MAX) | (de_cnt_n == STA_MAX)
              | (vtot_n == STA_MAX) | (vact_n == STA_MAX);

    cur_t = '{htot: line_tot, hact: line_act, vtot: vtot, vact: vact};
    if (frm_sat) begin
      match_n = '0;
    end else if (prev_valid && cur_t == prev_t) begin
      match_n = (match_cnt == LOCK_MAX) ? match_cnt : match_cnt + 4'd1;
    end else begin
      match_n = '0;
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (!RST_IN || !CTL_RUN_IN) begin
      state           <= ST_IDLE;
      {h_cnt, de_cnt, line_tot, line_act, vtot, vact} <= '0;
      frm_sat         <= 1'b0;
      prev_t          <= '0;
      prev_valid      <= 1'b0;
      match_cnt       <= '0;
      upd_pend        <= 1'b0;
      STA_HTOTAL_OUT  <= '0;
      STA_HACT_OUT    <= '0;
      STA_VTOTAL_OUT  <= '0;
      STA_VACT_OUT    <= '0;
      STA_FRM_CNT_OUT <= '0;
      STA_LOCK_OUT    <= 1'b0;
    end else if (CKE_IN) begin
      upd_pend <= 1'b0;
      case (state)
        ST_IDLE:    state <= ST_SYNC;
        ST_SYNC:    if (vs_rise) state <= ST_MEASURE;
        ST_MEASURE: state <= ST_MEASURE;
        default:    state <= ST_IDLE;
      endcase
      if (state == ST_MEASURE || frame_start) begin
        h_cnt    <= h_cnt_n;
        de_cnt   <= de_cnt_n;
        line_tot <= line_tot_n;
        line_act <= line_act_n;
        vtot     <= vtot_n;
        vact     <= vact_n;
        frm_sat  <= frm_sat_n;
      end
      if (frame_close) begin
        STA_HTOTAL_OUT  <= cur_t.htot;
        STA_HACT_OUT    <= cur_t.hact;
        STA_VTOTAL_OUT  <= cur_t.vtot;
        STA_VACT_OUT    <= cur_t.vact;
        STA_FRM_CNT_OUT <= STA_FRM_CNT_OUT + 1'b1;
        STA_LOCK_OUT    <= (match_n == LOCK_MAX);
        match_cnt       <= match_n;
        prev_t          <= cur_t;
        prev_valid      <= 1'b1;
        upd_pend        <= 1'b1;
      end
    end
  end

  // Held until the next qualified cycle so the pulse lands on a CKE-high cycle.
  assign STA_UPD_OUT = upd_pend & CKE_IN;

`ifdef PRT_VTB_VTM_CRC_EN
  logic [P_BPC*P_PPC-1:0]   r_r, g_r, b_r;
  logic [3*P_BPC*P_PPC-1:0] crc_word;
  logic                     crc_clr, crc_en;
  logic [15:0]              crc_val;

  // NOTE: pixel registers carry no reset; DE qualifies every use of them
  always_ff @(posedge CLK_IN) begin
    if (CKE_IN) begin
      r_r <= VID_R_IN;
      g_r <= VID_G_IN;
      b_r <= VID_B_IN;
    end
  end

  always_comb begin
    crc_word = '0;
    for (int p = 0; p < P_PPC; p++) begin
      crc_word[(P_PPC-1-p)*3*P_BPC +: 3*P_BPC] =
        {r_r[p*P_BPC +: P_BPC], g_r[p*P_BPC +: P_BPC], b_r[p*P_BPC +: P_BPC]};
    end
  end

  assign crc_clr = !CTL_RUN_IN || (CKE_IN && (state == ST_IDLE || frame_start));
  assign crc_en  = CTL_RUN_IN && CKE_IN && de_r && (state == ST_MEASURE || frame_start);

  prt_vtb_vtm_crc #(.P_W(3*P_BPC*P_PPC)) u_crc (
    .clk   (CLK_IN),
    .rst_n (RST_IN),
    .clr   (crc_clr),
    .en    (crc_en),
    .data  (crc_word),
    .crc   (crc_val)
  );

  always_ff @(posedge CLK_IN) begin
    if (!RST_IN || !CTL_RUN_IN) begin
      STA_CRC_OUT <= '0;
    end else if (CKE_IN && frame_close) begin
      STA_CRC_OUT <= crc_val;
    end
  end
`else
  logic unused_pix;
  assign unused_pix  = ^{VID_R_IN, VID_G_IN, VID_B_IN};
  assign STA_CRC_OUT = '0;
`endif

endmodule
